// File: rtl/monitor_dbg_input_cond.sv
// Input conditioner feeding the debug PIO in_port: per-bit synchroniser and
// debouncer, with output freeze, sticky rising-edge capture and a change strobe.
module monitor_dbg_input_cond #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             freeze,
  input  logic [WIDTH-1:0] edge_clr,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] edge_cap,
  output logic             change_pulse
);

  // Terminal count: the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic             change_q, change_d;
  logic [WIDTH-1:0] sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: plain shift, nothing between stages.
  always_comb begin
    sync_d[0] = raw_in;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Per-bit debounce; a partial count is dropped as soon as the input agrees again.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_s[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TERM) begin
        stable_d[i] = sync_s[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Output word, sticky edge flags (set beats clear) and change strobe.
  always_comb begin
    if (freeze) begin
      out_d = out_q;
    end else begin
      out_d = stable_d;
    end
    edge_d   = (edge_q & ~edge_clr) | (stable_d & ~stable_q);
    change_d = |(stable_d ^ stable_q);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q <= '0;
      out_q    <= '0;
      edge_q   <= '0;
      change_q <= 1'b0;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q <= stable_d;
      out_q    <= out_d;
      edge_q   <= edge_d;
      change_q <= change_d;
    end
  end

  assign out_data     = out_q;
  assign edge_cap     = edge_q;
  assign change_pulse = change_q;

endmodule

// File: tb/tb_monitor_dbg_input_cond.sv
// Bench for monitor_dbg_input_cond: directed scenarios plus random traffic,
// checked against a window-based model of the debounce rules.
module tb_monitor_dbg_input_cond;

  localparam int W   = 16;
  localparam int SYN = 2;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic         freeze = 1'b0;
  logic [W-1:0] edge_clr = '0;
  logic [W-1:0] out_data, edge_cap;
  logic         change_pulse;

  int errors = 0;
  int checks = 0;

  // Model: stable bit flips once the last DEB synchronised samples, all taken
  // since that bit's previous change, disagree with it.
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] s_hist[$];
  int           edge_n;
  int           last_chg[W];
  logic [W-1:0] m_stable, exp_out, exp_edge;
  logic         exp_chg;

  monitor_dbg_input_cond #(.WIDTH(W), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .freeze(freeze), .edge_clr(edge_clr),
    .out_data(out_data), .edge_cap(edge_cap), .change_pulse(change_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    raw_hist.delete();
    s_hist.delete();
    edge_n = 0;
    for (int i = 0; i < W; i++) last_chg[i] = 0;
    m_stable = '0; exp_out = '0; exp_edge = '0; exp_chg = 1'b0;
  endtask

  task automatic tick();
    logic [W-1:0] s_now, ns;
    bit all_diff;
    @(posedge clk);
    edge_n++;
    raw_hist.push_back(raw_in);
    s_now = (edge_n > SYN) ? raw_hist[edge_n-1-SYN] : '0;
    s_hist.push_back(s_now);
    ns = m_stable;
    for (int i = 0; i < W; i++) begin
      if (edge_n - last_chg[i] >= DEB) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++)
          if (s_hist[edge_n-1-k][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          ns[i] = ~m_stable[i];
          last_chg[i] = edge_n;
        end
      end
    end
    exp_chg  = (ns != m_stable);
    exp_edge = (exp_edge & ~edge_clr) | (ns & ~m_stable);
    if (!freeze) exp_out = ns;
    m_stable = ns;
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_data !== 16'h0000 || edge_cap !== 16'h0000 || change_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_value out=%h edge=%h chg=%b need 0000/0000/0", out_data, edge_cap, change_pulse);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      tick();
      checks++;
      if (out_data !== 16'h0000 || edge_cap !== 16'h0000 || change_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle out=%h edge=%h chg=%b need 0000/0000/0", out_data, edge_cap, change_pulse);
      end
    end
  endtask

  task automatic test_basic();
    raw_in = 16'h00A5;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (out_data !== exp_out || edge_cap !== exp_edge || change_pulse !== exp_chg) begin
        errors++;
        $display("FAIL basic e%0d out=%h/%h edge=%h/%h chg=%b/%b", e, out_data, exp_out, edge_cap, exp_edge, change_pulse, exp_chg);
      end
      checks++;
      if (out_data !== ((e >= 6) ? 16'h00A5 : 16'h0000) || change_pulse !== (e == 6)) begin
        errors++;
        $display("FAIL basic_latency e%0d out=%h chg=%b", e, out_data, change_pulse);
      end
    end
    checks++;
    if (edge_cap !== 16'h00A5) begin
      errors++;
      $display("FAIL basic_edge got=%h need=00a5", edge_cap);
    end
  endtask

  task automatic test_bounce();
    int pulses;
    raw_in = 16'h00A4;
    repeat (10) tick();
    raw_in = 16'h00A5;
    repeat (3) tick();
    raw_in = 16'h00A4;
    repeat (10) begin
      tick();
      checks++;
      if (out_data !== 16'h00A4 || change_pulse !== 1'b0 || out_data !== exp_out) begin
        errors++;
        $display("FAIL bounce_short out=%h chg=%b need 00a4/0", out_data, change_pulse);
      end
    end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) raw_in[0] = ~raw_in[0];
      tick();
      if (change_pulse) pulses++;
      checks++;
      if (out_data !== exp_out || change_pulse !== exp_chg) begin
        errors++;
        $display("FAIL bounce_toggle c%0d out=%h/%h chg=%b/%b", c, out_data, exp_out, change_pulse, exp_chg);
      end
    end
    raw_in = 16'h00A5;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (change_pulse) pulses++;
      checks++;
      if (out_data[0] !== (e >= 6) || out_data !== exp_out) begin
        errors++;
        $display("FAIL bounce_settle e%0d out=%h/%h", e, out_data, exp_out);
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL bounce_pulses got=%0d need=1", pulses);
    end
  endtask

  task automatic test_freeze();
    int pulses = 0;
    freeze = 1'b1;
    raw_in = 16'hFFFF;
    repeat (10) begin
      tick();
      if (change_pulse) pulses++;
      checks++;
      if (out_data !== 16'h00A5 || edge_cap !== exp_edge) begin
        errors++;
        $display("FAIL freeze_hold out=%h need 00a5 edge=%h/%h", out_data, edge_cap, exp_edge);
      end
    end
    checks++;
    if (pulses !== 1 || edge_cap !== 16'hFFFF) begin
      errors++;
      $display("FAIL freeze_side pulses=%0d edge=%h need 1/ffff", pulses, edge_cap);
    end
    freeze = 1'b0;
    tick();
    checks++;
    if (out_data !== 16'hFFFF || out_data !== exp_out) begin
      errors++;
      $display("FAIL freeze_release out=%h need ffff", out_data);
    end
  endtask

  task automatic test_edge_clr();
    raw_in = 16'hFFFE;
    edge_clr = 16'h0001;
    tick();
    edge_clr = 16'h0000;
    repeat (9) tick();
    raw_in = 16'hFFFF;
    repeat (5) tick();
    edge_clr = 16'h0001;
    tick();
    checks++;
    if (edge_cap !== 16'hFFFF || out_data !== 16'hFFFF || edge_cap !== exp_edge) begin
      errors++;
      $display("FAIL edge_set_wins edge=%h out=%h need ffff/ffff", edge_cap, out_data);
    end
    tick();
    edge_clr = 16'h0000;
    checks++;
    if (edge_cap !== 16'hFFFE || edge_cap !== exp_edge) begin
      errors++;
      $display("FAIL edge_clear edge=%h need fffe", edge_cap);
    end
  endtask

  task automatic test_reset_mid();
    raw_in = 16'h8000;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (out_data !== 16'h0000 || edge_cap !== 16'h0000 || change_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_async out=%h edge=%h chg=%b need zeros", out_data, edge_cap, change_pulse);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (out_data !== ((e >= 6) ? 16'h8000 : 16'h0000) || out_data !== exp_out ||
          edge_cap !== exp_edge || change_pulse !== exp_chg) begin
        errors++;
        $display("FAIL reset_requal e%0d out=%h/%h edge=%h/%h chg=%b/%b", e, out_data, exp_out, edge_cap, exp_edge, change_pulse, exp_chg);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) raw_in = raw_in ^ W'($urandom_range(0, 65535) & $urandom_range(0, 65535));
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      edge_clr = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 65535)) : '0;
      tick();
      checks++;
      if (out_data !== exp_out || edge_cap !== exp_edge || change_pulse !== exp_chg) begin
        errors++;
        $display("FAIL random c%0d out=%h/%h edge=%h/%h chg=%b/%b", c, out_data, exp_out, edge_cap, exp_edge, change_pulse, exp_chg);
      end
    end
    freeze = 1'b0;
    edge_clr = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_bounce();
    test_freeze();
    test_edge_clr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/monitor_dbg_input_cond.md
Name: monitor_dbg_input_cond

Overview:
Input conditioner placed directly upstream of the monitor's 16-bit debug-data PIO. It synchronises asynchronous board and debug inputs and debounces each bit. The debounced word drives the PIO's in_port, so the Avalon reader always sees clean, glitch-free data. It also provides a freeze/hold function, a sticky per-bit rising-edge capture register, and a change strobe.

Parameters:
WIDTH, 16, number of conditioned input bits (matches PIO in_port width)
SYNC_STAGES, 2, flip-flops in each synchroniser chain (minimum 2)
DEBOUNCE_CYCLES, 50000, consecutive clk cycles of stable mismatch required before the output bit updates (1 ms at 50 MHz); value 1 = no debounce
CNT_W, 16, per-bit debounce counter width; DEBOUNCE_CYCLES <= 2**CNT_W

Ports:
clk  input  1  system clock; all logic in this single domain
reset  input  1  asynchronous, active-high reset
raw_in  input  WIDTH  asynchronous raw inputs (switches, probes)
freeze  input  1  1 = hold out_data at its current value
edge_clr  input  WIDTH  per-bit synchronous clear for edge_cap
out_data  output  WIDTH  debounced (optionally frozen) word; connects to the PIO in_port
edge_cap  output  WIDTH  sticky rising-edge flags of the debounced bits
change_pulse  output  1  one-cycle strobe on any debounced-bit change

Behaviour:
- Reset (async assert, sync release): sync chains, stable register, counters, out_data, edge_cap and change_pulse all 0.
- Sync: raw_in[i] -> SYNC_STAGES-deep flop chain -> s[i]. No logic between the stages.
- Debounce (per bit, independent): stable[i] and cnt[i] are registered.
  - s[i] == stable[i]: cnt <= 0.
  - s[i] != stable[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s[i] != stable[i] and cnt == DEBOUNCE_CYCLES-1: stable <= s[i]; cnt <= 0.
  - Any return to equality before the terminal count discards the partial count. Glitches shorter than DEBOUNCE_CYCLES never propagate.
  - The counter never wraps. The terminal compare must be exact.
- Latency: raw_in steady from before clock edge 1 -> stable, out_data, change_pulse and edge_cap update on edge SYNC_STAGES+DEBOUNCE_CYCLES.
- out_data:
  - freeze=0: out_data loads the next-state value of stable on the same edge (no extra latency).
  - freeze=1: out_data holds. Debounce, edge_cap and change_pulse continue to operate.
  - freeze falling: out_data loads the current stable on the next edge.
- change_pulse: registered. High for exactly one cycle on each edge where any stable bit changes. Simultaneous changes on several bits produce a single pulse. Independent of freeze.
- edge_cap[i]: set on the edge where stable[i] goes 0->1. Cleared on an edge where edge_clr[i]=1. Set wins over clear in the same cycle. Falling transitions do not affect it.
- Reset mid-debounce: all partial counts are lost and outputs return to 0. After release, inputs are re-qualified from scratch.
- DEBOUNCE_CYCLES=1: stable follows s with one cycle of latency.

Test Plan:
Use WIDTH=16, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 throughout.
1. Reset with raw_in=0x0000 -> out_data=0x0000, edge_cap=0x0000, change_pulse=0. Hold 10 cycles -> nothing changes.
2. raw_in 0x0000->0x00A5, held -> out_data=0x00A5 exactly on edge 6. change_pulse high only in that cycle. edge_cap=0x00A5.
3. Bounce rejection:
   - bit0 high for 3 cycles, then low -> out_data and change_pulse unchanged.
   - bit0 toggling every 2 cycles for 20 cycles, then steady 1 -> out_data[0]=1 on edge 6 after the last transition. Exactly one change_pulse.
4. Freeze:
   - freeze=1, raw_in=0xFFFF -> out_data stays 0x00A5. change_pulse fires once. edge_cap=0xFFFF.
   - freeze=0 -> out_data=0xFFFF on the next edge.
5. edge_clr=0x0001 asserted on the same edge that stable[0] rises -> edge_cap[0] stays 1. edge_clr=0x0001 one cycle later -> edge_cap[0]=0, other bits unaffected.
6. raw_in=0x8000, reset asserted 3 edges after the mismatch starts -> all outputs 0 immediately (asynchronous). Release with raw_in still 0x8000 -> out_data=0x8000 on edge 6 after release.
